// File: rtl/tsm_fltr_regbank.sv
// tsm_fltr_regbank: APB register bank for the MAC filter.
// Holds filter control, hash table, station-address entries with enables and
// saturating event counters (clear-on-read / write-1-clear, sticky saturation).
// APB slave with exactly one wait state: pready is registered and pulses for one cycle.
module tsm_fltr_regbank #(
    parameter int NUM_STA   = 4,
    parameter int HASH_BITS = 64,
    parameter int NUM_CNT   = 2,
    parameter int CNT_W     = 32
) (
    input  logic                   hst_clk_i,
    input  logic                   hst_rst_i,
    input  logic                   hst_psel_i,
    input  logic                   hst_penable_i,
    input  logic                   hst_pwrite_i,
    input  logic [7:0]             hst_paddr_i,
    input  logic [31:0]            hst_pwdata_i,
    output logic [31:0]            hst_prdata_o,
    output logic                   hst_pready_o,
    output logic                   hst_pslverr_o,
    input  logic [NUM_CNT-1:0]     cnt_inc_i,
    output logic [5:0]             fltrctrl_o,
    output logic [10:0]            tsm_control_o,
    output logic [HASH_BITS-1:0]   hash_tbl_o,
    output logic [48*NUM_STA-1:0]  sta_addr_o,
    output logic [NUM_STA-1:0]     sta_en_o
);
    localparam int               HASH_W   = HASH_BITS / 32;
    localparam logic [47:0]      STA0_RST = 48'hC0B1_3C88_8888;
    localparam logic [10:0]      CTRL_RST = 11'b0101_0000_110;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Register state
    logic [5:0]                       fltctrl_q;
    logic [10:0]                      ctrl_q;
    logic                             coren_q;
    logic [NUM_STA-1:0]               staen_q;
    logic [HASH_W-1:0][31:0]          hash_q;
    logic [31:0]                      stage_q;
    logic [NUM_STA-1:0][47:0]         sta_q;
    logic [NUM_CNT-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CNT-1:0]               sat_q, sat_d;
    logic [NUM_CNT-1:0]               cnt_clr;

    // Bus response state
    logic                             pready_q;
    logic                             pslverr_q;
    logic [31:0]                      prdata_q;

    logic                             acc_start, wr_acc, rd_acc;
    logic                             addr_hit;
    logic [31:0]                      rdata;

    // Station address bytes appear reversed on the bus; the swap is its own inverse.
    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // The access edge is the one that raises pready; a held penable while
    // pready is high never re-triggers, so a transfer commits once.
    assign acc_start = hst_psel_i & hst_penable_i & ~pready_q;
    assign wr_acc    = acc_start & hst_pwrite_i;
    assign rd_acc    = acc_start & ~hst_pwrite_i;

    // Read mux and address decode; unmapped addresses read as zero.
    always_comb begin
        rdata    = '0;
        addr_hit = 1'b0;
        case (hst_paddr_i)
            8'h00: begin addr_hit = 1'b1; rdata[5:0]  = fltctrl_q; end
            8'h01: begin addr_hit = 1'b1; rdata[10:0] = ctrl_q;    end
            8'h02: begin
                addr_hit              = 1'b1;
                rdata[0]              = coren_q;
                rdata[16 +: NUM_CNT]  = sat_q;
            end
            8'h03: begin addr_hit = 1'b1; rdata[NUM_STA-1:0] = staen_q; end
            default: ;
        endcase
        for (int k = 0; k < HASH_W; k++) begin
            if (hst_paddr_i == 8'(4 + k)) begin
                addr_hit = 1'b1;
                rdata    = hash_q[k];
            end
        end
        for (int i = 0; i < NUM_STA; i++) begin
            if (hst_paddr_i == 8'(32 + 2*i)) begin
                addr_hit = 1'b1;
                rdata    = bswap(sta_q[i][31:0]);
            end
            if (hst_paddr_i == 8'(33 + 2*i)) begin
                addr_hit = 1'b1;
                rdata    = {sta_q[i][39:32], sta_q[i][47:40], 16'h0000};
            end
        end
        for (int j = 0; j < NUM_CNT; j++) begin
            if (hst_paddr_i == 8'(64 + j)) begin
                addr_hit = 1'b1;
                rdata    = 32'(cnt_q[j]);
            end
        end
    end

    // Counter next-state: clear beats increment except the increment itself
    // survives, so a clear coinciding with an event leaves the count at 1.
    always_comb begin
        cnt_clr = '0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        for (int j = 0; j < NUM_CNT; j++) begin
            cnt_clr[j] = (wr_acc && hst_paddr_i == 8'h02 && hst_pwdata_i[8+j]) ||
                         (rd_acc && coren_q && hst_paddr_i == 8'(64 + j));
            if (cnt_clr[j])
                cnt_d[j] = cnt_inc_i[j] ? CNT_ONE : '0;
            else if (cnt_inc_i[j] && cnt_q[j] != CNT_MAX)
                cnt_d[j] = cnt_q[j] + CNT_ONE;
            if (wr_acc && hst_paddr_i == 8'h02 && hst_pwdata_i[16+j])
                sat_d[j] = 1'b0;
            // A new saturation event wins over a simultaneous flag clear.
            if (cnt_inc_i[j] && cnt_d[j] == CNT_MAX)
                sat_d[j] = 1'b1;
        end
    end

    // Control, hash and station registers; writes commit on the access edge.
    always_ff @(posedge hst_clk_i or posedge hst_rst_i) begin
        if (hst_rst_i) begin
            fltctrl_q <= 6'h3F;
            ctrl_q    <= CTRL_RST;
            coren_q   <= 1'b0;
            staen_q   <= '0;
            hash_q    <= '0;
            stage_q   <= '0;
            for (int i = 0; i < NUM_STA; i++)
                sta_q[i] <= (i == 0) ? STA0_RST : 48'h0;
        end else if (wr_acc) begin
            case (hst_paddr_i)
                8'h00: fltctrl_q <= hst_pwdata_i[5:0];
                8'h01: ctrl_q    <= hst_pwdata_i[10:0];
                8'h02: coren_q   <= hst_pwdata_i[0];
                8'h03: staen_q   <= hst_pwdata_i[NUM_STA-1:0];
                default: ;
            endcase
            for (int k = 0; k < HASH_W; k++)
                if (hst_paddr_i == 8'(4 + k))
                    hash_q[k] <= hst_pwdata_i;
            for (int i = 0; i < NUM_STA; i++) begin
                // Low half only stages; the datapath sees a whole address at once.
                if (hst_paddr_i == 8'(32 + 2*i))
                    stage_q <= bswap(hst_pwdata_i);
                if (hst_paddr_i == 8'(33 + 2*i))
                    sta_q[i] <= {hst_pwdata_i[23:16], hst_pwdata_i[31:24], stage_q};
            end
        end
    end

    // Event counters and sticky saturation flags.
    always_ff @(posedge hst_clk_i or posedge hst_rst_i) begin
        if (hst_rst_i) begin
            cnt_q <= '0;
            sat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // APB response: one-cycle pready, read data and error latched with it.
    always_ff @(posedge hst_clk_i or posedge hst_rst_i) begin
        if (hst_rst_i) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= acc_start;
            pslverr_q <= acc_start & ~addr_hit;
            if (acc_start)
                prdata_q <= hst_pwrite_i ? 32'h0 : rdata;
        end
    end

    assign hst_prdata_o  = prdata_q;
    assign hst_pready_o  = pready_q;
    assign hst_pslverr_o = pslverr_q;
    assign fltrctrl_o    = fltctrl_q;
    assign tsm_control_o = ctrl_q;
    assign hash_tbl_o    = hash_q;
    assign sta_addr_o    = sta_q;
    assign sta_en_o      = staen_q;

endmodule

// File: tb/tb_tsm_fltr_regbank.sv
// Bench for tsm_fltr_regbank: vector table, hand sequences for counters/stations/reset,
// and a randomized phase checked against a register-level model.
module tb_tsm_fltr_regbank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        psel0, psel1, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;

    logic [31:0]  prdata0;  logic pready0, pslverr0;
    logic [1:0]   inc0;
    logic [5:0]   fltr0;    logic [10:0] ctrl0;
    logic [63:0]  hash0;    logic [191:0] sta0; logic [3:0] staen0;

    logic [31:0]  prdata1;  logic pready1, pslverr1;
    logic [0:0]   inc1;
    logic [5:0]   fltr1;    logic [10:0] ctrl1;
    logic [63:0]  hash1;    logic [47:0] sta1;  logic [0:0] staen1;

    tsm_fltr_regbank u_dut (
        .hst_clk_i(clk), .hst_rst_i(rst), .hst_psel_i(psel0), .hst_penable_i(penable),
        .hst_pwrite_i(pwrite), .hst_paddr_i(paddr), .hst_pwdata_i(pwdata),
        .hst_prdata_o(prdata0), .hst_pready_o(pready0), .hst_pslverr_o(pslverr0),
        .cnt_inc_i(inc0), .fltrctrl_o(fltr0), .tsm_control_o(ctrl0),
        .hash_tbl_o(hash0), .sta_addr_o(sta0), .sta_en_o(staen0));

    tsm_fltr_regbank #(.NUM_STA(1), .HASH_BITS(64), .NUM_CNT(1), .CNT_W(16)) u_dut16 (
        .hst_clk_i(clk), .hst_rst_i(rst), .hst_psel_i(psel1), .hst_penable_i(penable),
        .hst_pwrite_i(pwrite), .hst_paddr_i(paddr), .hst_pwdata_i(pwdata),
        .hst_prdata_o(prdata1), .hst_pready_o(pready1), .hst_pslverr_o(pslverr1),
        .cnt_inc_i(inc1), .fltrctrl_o(fltr1), .tsm_control_o(ctrl1),
        .hash_tbl_o(hash1), .sta_addr_o(sta1), .sta_en_o(staen1));

    int checks = 0;
    int failures = 0;
    logic [31:0] rdv;
    logic        erv;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       name;
    } vec_t;
    vec_t tbl[$];

    // Register-level model for the random phase
    int unsigned mcnt[2];
    bit          mcoren;
    logic [31:0] mhash[2];
    logic [3:0]  mstaen;
    logic [47:0] msta[4];
    logic [31:0] mlo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; checks that pready is low in the first access cycle,
    // high in the second and low afterwards.
    task automatic apb(input bit dev, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input bit inc_hit, output logic [31:0] rd, output logic err);
        logic [2:0] hs;
        @(negedge clk);
        psel0 = ~dev; psel1 = dev; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        if (inc_hit) inc0[0] = 1'b1;
        hs[2] = dev ? pready1 : pready0;
        @(negedge clk);
        if (inc_hit) inc0[0] = 1'b0;
        hs[1] = dev ? pready1 : pready0;
        rd    = dev ? prdata1 : prdata0;
        err   = dev ? pslverr1 : pslverr0;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        hs[0] = dev ? pready1 : pready0;
        chk("handshake", 64'(hs), 64'h2);
    endtask

    task automatic wrp(input bit dev, input logic [7:0] a, input logic [31:0] d);
        apb(dev, 1'b1, a, d, 1'b0, rdv, erv);
    endtask

    task automatic rdchk(input bit dev, input logic [7:0] a, input logic [31:0] exp, input string name);
        apb(dev, 1'b0, a, 32'h0, 1'b0, rdv, erv);
        chk(name, 64'(rdv), 64'(exp));
    endtask

    task automatic pulse(input int n, input logic [1:0] m);
        repeat (n) begin
            @(negedge clk); inc0 = m;
            @(negedge clk); inc0 = 2'b00;
        end
    endtask

    task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_err = ee; v.name = nm;
        tbl.push_back(v);
    endtask

    // Station address byte k on the bus: LO data holds bytes 0..3 MSB-first,
    // HI data bits [31:16] hold bytes 4,5.
    function automatic logic [47:0] sta_of(input logic [31:0] lo_d, input logic [31:0] hi_d);
        logic [47:0] e;
        e = '0;
        for (int b = 0; b < 4; b++) e[8*b +: 8] = lo_d[8*(3-b) +: 8];
        e[39:32] = hi_d[31:24];
        e[47:40] = hi_d[23:16];
        return e;
    endfunction

    function automatic logic [31:0] lo_of(input logic [47:0] e);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[8*(3-b) +: 8] = e[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        mcnt[0] = 0; mcnt[1] = 0; mcoren = 1'b0;
        mhash[0] = '0; mhash[1] = '0; mstaen = '0; mlo = '0;
        msta[0] = 48'hC0B1_3C88_8888; msta[1] = '0; msta[2] = '0; msta[3] = '0;
    endtask

    initial begin
        rst = 1'b1; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; inc0 = '0; inc1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state of outputs
        chk("rst_pready",  64'(pready0),  64'h0);
        chk("rst_pslverr", 64'(pslverr0), 64'h0);
        chk("rst_prdata",  64'(prdata0),  64'h0);
        chk("rst_fltr",    64'(fltr0),    64'h3F);
        chk("rst_ctrl",    64'(ctrl0),    64'h286);
        chk("rst_hash",    hash0,         64'h0);
        chk("rst_staen",   64'(staen0),   64'h0);
        chk("rst_sta0",    64'(sta0[47:0]),    64'hC0B1_3C88_8888);
        chk("rst_sta1",    64'(sta0[95:48]),   64'h0);
        chk("rst_sta23",   64'(sta0[191:96] != 0), 64'h0);

        // Vector table against the default-parameter instance
        add(0, 8'h00, 0, 32'h3F,        0, "rd_fltctrl");
        add(0, 8'h01, 0, 32'h286,       0, "rd_ctrl");
        add(0, 8'h02, 0, 32'h0,         0, "rd_cntctrl");
        add(0, 8'h03, 0, 32'h0,         0, "rd_staen");
        add(0, 8'h04, 0, 32'h0,         0, "rd_hash0");
        add(0, 8'h20, 0, 32'h8888883C,  0, "rd_sta0_lo");
        add(0, 8'h21, 0, 32'hB1C00000,  0, "rd_sta0_hi");
        add(0, 8'h22, 0, 32'h0,         0, "rd_sta1_lo");
        add(0, 8'h27, 0, 32'h0,         0, "rd_sta3_hi");
        add(0, 8'h40, 0, 32'h0,         0, "rd_cnt0");
        add(0, 8'h41, 0, 32'h0,         0, "rd_cnt1");
        add(0, 8'h06, 0, 32'h0,         1, "rd_unm06");
        add(0, 8'h07, 0, 32'h0,         1, "rd_unm07");
        add(0, 8'h28, 0, 32'h0,         1, "rd_unm28");
        add(0, 8'h42, 0, 32'h0,         1, "rd_unm42");
        add(0, 8'hFF, 0, 32'h0,         1, "rd_unmFF");
        add(1, 8'h00, 32'h15,       0, 0, "wr_fltctrl");
        add(0, 8'h00, 0, 32'h15,        0, "rb_fltctrl");
        add(1, 8'h01, 32'hFFFFFFFF, 0, 0, "wr_ctrl");
        add(0, 8'h01, 0, 32'h7FF,       0, "rb_ctrl");
        add(1, 8'h03, 32'hFFFFFFFF, 0, 0, "wr_staen");
        add(0, 8'h03, 0, 32'hF,         0, "rb_staen");
        add(1, 8'h05, 32'hDEADBEEF, 0, 0, "wr_hash1");
        add(0, 8'h05, 0, 32'hDEADBEEF,  0, "rb_hash1");
        add(1, 8'h07, 32'h12345678, 0, 1, "wr_unm07");
        add(0, 8'h04, 0, 32'h0,         0, "rb_hash0");
        add(1, 8'h40, 32'h1234,     0, 0, "wr_cnt0_ro");
        add(0, 8'h40, 0, 32'h0,         0, "rb_cnt0_ro");
        foreach (tbl[n]) begin
            apb(1'b0, tbl[n].wr, tbl[n].addr, tbl[n].wd, 1'b0, rdv, erv);
            if (!tbl[n].wr) chk(tbl[n].name, 64'(rdv), 64'(tbl[n].exp_rd));
            chk({tbl[n].name, "_err"}, 64'(erv), 64'(tbl[n].exp_err));
        end
        chk("out_fltr",  64'(fltr0),  64'h15);
        chk("out_ctrl",  64'(ctrl0),  64'h7FF);
        chk("out_staen", 64'(staen0), 64'hF);
        chk("out_hash",  hash0,       64'hDEADBEEF_00000000);

        // Atomic station update
        wrp(0, 8'h22, 32'h11223344);
        chk("sta1_lo_only", 64'(sta0[95:48]), 64'h0);
        chk("sta0_kept",    64'(sta0[47:0]),  64'hC0B1_3C88_8888);
        rdchk(0, 8'h22, 32'h0, "sta1_lo_committed");
        wrp(0, 8'h23, 32'h55660000);
        chk("sta1_commit", 64'(sta0[95:48]), 64'h6655_4433_2211);
        rdchk(0, 8'h22, 32'h11223344, "sta1_lo_rb");
        rdchk(0, 8'h23, 32'h55660000, "sta1_hi_rb");

        // Counters: clear-on-read, clear+increment, W1C
        wrp(0, 8'h02, 32'h1);
        pulse(5, 2'b01);
        rdchk(0, 8'h40, 32'd5, "cor_first");
        rdchk(0, 8'h40, 32'd0, "cor_second");
        pulse(3, 2'b01);
        apb(1'b0, 1'b0, 8'h40, 32'h0, 1'b1, rdv, erv);
        chk("cor_inc_preclear", 64'(rdv), 64'd3);
        rdchk(0, 8'h40, 32'd1, "cor_inc_kept");
        rdchk(0, 8'h40, 32'd0, "cor_inc_cleared");
        wrp(0, 8'h02, 32'h0);
        pulse(2, 2'b01);
        rdchk(0, 8'h40, 32'd2, "nocor_1");
        rdchk(0, 8'h40, 32'd2, "nocor_2");
        pulse(4, 2'b10);
        wrp(0, 8'h02, 32'h101);
        rdchk(0, 8'h40, 32'd0, "w1c_cnt0");
        rdchk(0, 8'h41, 32'd4, "w1c_cnt1_kept");
        rdchk(0, 8'h02, 32'h1, "cntctrl_w1c_reads0");

        // 16-bit counter saturation on the second instance
        @(negedge clk); inc1 = 1'b1;
        repeat (65537) @(negedge clk);
        inc1 = 1'b0;
        rdchk(1, 8'h40, 32'hFFFF,     "sat_value");
        rdchk(1, 8'h02, 32'h00010000, "sat_flag");
        wrp(1, 8'h02, 32'h00000100);
        rdchk(1, 8'h40, 32'h0,        "sat_cleared_cnt");
        rdchk(1, 8'h02, 32'h00010000, "sat_flag_sticky");
        wrp(1, 8'h02, 32'h00010000);
        rdchk(1, 8'h02, 32'h0,        "sat_flag_w1c");

        // Randomized phase against the model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    int n; logic [1:0] m;
                    n = int'($urandom_range(1, 4));
                    m = 2'($urandom_range(1, 3));
                    pulse(n, m);
                    if (m[0]) mcnt[0] += n;
                    if (m[1]) mcnt[1] += n;
                end
                1: begin
                    int j;
                    j = int'($urandom_range(0, 1));
                    rdchk(0, 8'(64 + j), mcnt[j], "rnd_cnt");
                    if (mcoren) mcnt[j] = 0;
                end
                2: begin
                    logic [31:0] d;
                    d = $urandom & 32'h0003_0301;
                    wrp(0, 8'h02, d);
                    mcoren = d[0];
                    if (d[8]) mcnt[0] = 0;
                    if (d[9]) mcnt[1] = 0;
                    rdchk(0, 8'h02, 32'(mcoren), "rnd_cntctrl");
                end
                3: begin
                    int k; logic [31:0] d;
                    k = int'($urandom_range(0, 1));
                    d = $urandom;
                    wrp(0, 8'(4 + k), d);
                    mhash[k] = d;
                    k = int'($urandom_range(0, 1));
                    rdchk(0, 8'(4 + k), mhash[k], "rnd_hash");
                end
                4: begin
                    int i; logic [31:0] d;
                    i = int'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) begin
                        d = $urandom;
                        wrp(0, 8'(32 + 2*i), d);
                        mlo = d;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        d = $urandom;
                        wrp(0, 8'(33 + 2*i), d);
                        msta[i] = sta_of(mlo, d);
                    end
                    for (int s = 0; s < 4; s++) chk("rnd_sta_out", 64'(sta0[48*s +: 48]), 64'(msta[s]));
                    rdchk(0, 8'(32 + 2*i), lo_of(msta[i]), "rnd_sta_lo");
                    rdchk(0, 8'(33 + 2*i), {msta[i][39:32], msta[i][47:40], 16'h0}, "rnd_sta_hi");
                end
                default: begin
                    logic [31:0] d;
                    d = $urandom;
                    wrp(0, 8'h03, d);
                    mstaen = d[3:0];
                    chk("rnd_staen", 64'(staen0), 64'(mstaen));
                end
            endcase
        end
        chk("rnd_hash_out", hash0, {mhash[1], mhash[0]});
        rdchk(0, 8'h40, mcnt[0], "rnd_final_cnt0");
        rdchk(0, 8'h41, mcnt[1], "rnd_final_cnt1");

        // Reset asserted during the wait state of a HASH0 write
        wrp(0, 8'h04, 32'h0);
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hA5A5A5A5;
        @(negedge clk);
        penable = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pready", 64'(pready0), 64'h0);
        chk("rst_mid_hash",   hash0,        64'h0);
        psel0 = 1'b0; penable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_pready2", 64'(pready0), 64'h0);
        chk("rst_mid_fltr",    64'(fltr0),   64'h3F);
        rdchk(0, 8'h04, 32'h0, "rst_mid_hash_rb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
